// File: rtl/gt_rx_frame_aligner_if.sv
// Receive-side bundle between a raw GT wrapper and the frame aligner.
// The master drives the raw word and realign pulse; the slave returns aligned data and status.
interface gt_rx_frame_aligner_if #(
  parameter int DATA_W = 20,
  parameter int CNT_W  = 16,
  parameter int OFF_W  = $clog2(DATA_W)
);
  // Stream semantics: no backpressure. Every data_clk edge carries one data_in word,
  // and data_out is a real word exactly on the cycles where data_valid is high.
  logic [DATA_W-1:0] data_in;
  logic              force_realign;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              frame_start;
  logic              locked;
  logic [OFF_W-1:0]  bit_offset;
  logic [CNT_W-1:0]  lock_loss_cnt;
  logic [CNT_W-1:0]  hdr_err_cnt;
  logic [1:0]        fsm_state;

  modport master (
    output data_in, force_realign,
    input  data_out, data_valid, frame_start, locked, bit_offset,
           lock_loss_cnt, hdr_err_cnt, fsm_state
  );

  modport slave (
    input  data_in, force_realign,
    output data_out, data_valid, frame_start, locked, bit_offset,
           lock_loss_cnt, hdr_err_cnt, fsm_state
  );
endinterface

// File: rtl/gt_rx_frame_aligner.sv
// Bit-slip word aligner with HUNT/VERIFY/LOCKED frame-lock FSM for raw GT receive words.
// fsm_state exposes the state register: 0 = HUNT, 1 = VERIFY, 2 = LOCKED.
module gt_rx_frame_aligner #(
  parameter int                DATA_W       = 20,
  parameter logic [DATA_W-1:0] SYNC_PATTERN = 20'hF0A35,
  parameter int                FRAME_LEN    = 16,
  parameter int                LOCK_COUNT   = 4,
  parameter int                UNLOCK_COUNT = 3,
  parameter int                CNT_W        = 16
) (
  input  logic                  data_clk,
  input  logic                  rxresetdone_in,
  gt_rx_frame_aligner_if.slave  rx
);

  localparam int OFF_W = $clog2(DATA_W);
  localparam int SEL_W = OFF_W + 1;
  localparam int FC_W  = $clog2(FRAME_LEN);
  localparam int GD_W  = $clog2(LOCK_COUNT + 1);
  localparam int BD_W  = $clog2(UNLOCK_COUNT + 1);
  localparam bit LOCK_ON_FIRST = (LOCK_COUNT == 1);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [OFF_W-1:0]  offset_q, offset_d;
  logic [DATA_W-1:0] prev_q;
  logic [FC_W-1:0]   fcnt_q, fcnt_d;
  logic [GD_W-1:0]   good_q, good_d;
  logic [BD_W-1:0]   bad_q, bad_d;
  logic [CNT_W-1:0]  lock_loss_q, lock_loss_d;
  logic [CNT_W-1:0]  hdr_err_q, hdr_err_d;
  logic [DATA_W-1:0] data_out_q;
  logic              data_valid_q, frame_start_q, locked_q;
  logic              locked_d, frame_start_d;

  logic [2*DATA_W-1:0] win;
  logic [SEL_W-1:0]    sel;
  logic [DATA_W-1:0]   aligned;
  logic                hit;
  logic                hdr_slot;
  logic                frame_hdr;
  logic [OFF_W-1:0]    offset_inc;
  logic [FC_W-1:0]     fcnt_next;
  logic [GD_W-1:0]     good_inc;
  logic [BD_W-1:0]     bad_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Older word sits in the low half so bit order stays contiguous across the boundary.
  assign win     = {rx.data_in, prev_q};
  assign sel     = {1'b0, offset_q};
  assign aligned = win[sel +: DATA_W];
  assign hit     = (aligned == SYNC_PATTERN);

  assign hdr_slot   = (fcnt_q == '0);
  assign offset_inc = (offset_q == OFF_W'(DATA_W - 1)) ? '0 : offset_q + OFF_W'(1);
  assign fcnt_next  = (fcnt_q == FC_W'(FRAME_LEN - 1)) ? '0 : fcnt_q + FC_W'(1);
  assign good_inc   = good_q + GD_W'(1);
  assign bad_inc    = bad_q + BD_W'(1);

  always_comb begin
    state_d     = state_q;
    offset_d    = offset_q;
    fcnt_d      = fcnt_q;
    good_d      = good_q;
    bad_d       = bad_q;
    lock_loss_d = lock_loss_q;
    hdr_err_d   = hdr_err_q;
    frame_hdr   = 1'b0;

    case (state_q)
      ST_HUNT: begin
        fcnt_d = '0;
        good_d = '0;
        bad_d  = '0;
        if (hit) begin
          fcnt_d    = FC_W'(1);
          good_d    = GD_W'(1);
          frame_hdr = 1'b1;
          state_d   = LOCK_ON_FIRST ? ST_LOCKED : ST_VERIFY;
        end else begin
          offset_d = offset_inc;
        end
      end

      ST_VERIFY: begin
        fcnt_d = fcnt_next;
        if (hdr_slot) begin
          frame_hdr = 1'b1;
          if (hit) begin
            good_d = good_inc;
            if (good_inc == GD_W'(LOCK_COUNT)) state_d = ST_LOCKED;
          end else begin
            good_d   = '0;
            offset_d = offset_inc;
            state_d  = ST_HUNT;
          end
        end
      end

      ST_LOCKED: begin
        fcnt_d = fcnt_next;
        if (hdr_slot) begin
          frame_hdr = 1'b1;
          if (hit) begin
            bad_d = '0;
          end else begin
            hdr_err_d = sat_inc(hdr_err_q);
            bad_d     = bad_inc;
            if (bad_inc == BD_W'(UNLOCK_COUNT)) begin
              bad_d       = '0;
              lock_loss_d = sat_inc(lock_loss_q);
              state_d     = ST_HUNT;
            end
          end
        end
      end

      default: state_d = ST_HUNT;
    endcase

    // Realign wins over any transition above; a header error seen this cycle still counts.
    if (rx.force_realign) begin
      state_d     = ST_HUNT;
      offset_d    = offset_q;
      fcnt_d      = '0;
      good_d      = '0;
      bad_d       = '0;
      lock_loss_d = (state_q == ST_LOCKED) ? sat_inc(lock_loss_q) : lock_loss_q;
    end

    locked_d      = (state_d == ST_LOCKED);
    frame_start_d = locked_d & frame_hdr;
  end

  always_ff @(posedge data_clk or negedge rxresetdone_in) begin
    if (!rxresetdone_in) begin
      state_q       <= ST_HUNT;
      offset_q      <= '0;
      prev_q        <= '0;
      fcnt_q        <= '0;
      good_q        <= '0;
      bad_q         <= '0;
      lock_loss_q   <= '0;
      hdr_err_q     <= '0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      offset_q      <= offset_d;
      prev_q        <= rx.data_in;
      fcnt_q        <= fcnt_d;
      good_q        <= good_d;
      bad_q         <= bad_d;
      lock_loss_q   <= lock_loss_d;
      hdr_err_q     <= hdr_err_d;
      data_out_q    <= aligned;
      data_valid_q  <= locked_d;
      frame_start_q <= frame_start_d;
      locked_q      <= locked_d;
    end
  end

  assign rx.data_out      = data_out_q;
  assign rx.data_valid    = data_valid_q;
  assign rx.frame_start   = frame_start_q;
  assign rx.locked        = locked_q;
  assign rx.bit_offset    = offset_q;
  assign rx.lock_loss_cnt = lock_loss_q;
  assign rx.hdr_err_cnt   = hdr_err_q;
  assign rx.fsm_state     = state_q;

endmodule

// File: tb/tb_gt_rx_frame_aligner.sv
// Directed bench for gt_rx_frame_aligner: hunt/verify/lock timing, bit-shifted streams,
// header errors, forced realign, counter saturation (narrow counters) and async reset.
module tb_gt_rx_frame_aligner;

  localparam int          DATA_W       = 20;
  localparam int          FRAME_LEN    = 4;
  localparam int          LOCK_COUNT   = 4;
  localparam int          UNLOCK_COUNT = 3;
  localparam int          CNT_W        = 4;
  localparam logic [19:0] SYNC         = 20'hF0A35;
  localparam int          ST_HUNT      = 0;
  localparam int          ST_VERIFY    = 1;
  localparam int          ST_LOCKED    = 2;

  logic data_clk       = 1'b0;
  logic rxresetdone_in = 1'b0;

  gt_rx_frame_aligner_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) rx ();

  gt_rx_frame_aligner #(
    .DATA_W      (DATA_W),
    .SYNC_PATTERN(SYNC),
    .FRAME_LEN   (FRAME_LEN),
    .LOCK_COUNT  (LOCK_COUNT),
    .UNLOCK_COUNT(UNLOCK_COUNT),
    .CNT_W       (CNT_W)
  ) u_dut (
    .data_clk      (data_clk),
    .rxresetdone_in(rxresetdone_in),
    .rx            (rx)
  );

  // ---------------- clock / reset ----------------
  always #5 data_clk = ~data_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_dout;
  logic [DATA_W-1:0] t_prev;
  logic [DATA_W-1:0] tw;
  int                s_shift;
  int                n_checks;
  int                n_fail;
  int                nbad;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  // Raw GT word when the true word stream is delayed by s bits on the line.
  function automatic logic [DATA_W-1:0] raw_word(input logic [DATA_W-1:0] cur,
                                                 input logic [DATA_W-1:0] prev, input int s);
    logic [2*DATA_W-1:0] w;
    w = {cur, prev};
    w = w >> (DATA_W - s);
    return w[DATA_W-1:0];
  endfunction

  // True word i: header at i%4==ph from hdr_from on, payload nonzero from nz_from on.
  function automatic logic [DATA_W-1:0] tword(input int i, input int ph,
                                              input int hdr_from, input int nz_from);
    if (i >= hdr_from && (i % FRAME_LEN) == ph) return SYNC;
    if (i >= nz_from) return 20'h00C00 + 20'(i);
    return '0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [DATA_W-1:0] w, input logic fr);
    @(negedge data_clk);
    rx.data_in       = raw_word(w, t_prev, s_shift);
    rx.force_realign = fr;
    t_prev           = w;
    exp_q.push_back(w);
    @(posedge data_clk);
    #1;
    exp_dout = exp_q.pop_front();
  endtask

  task automatic hold_reset();
    rxresetdone_in   = 1'b0;
    rx.data_in       = '0;
    rx.force_realign = 1'b0;
    repeat (3) @(posedge data_clk);
    #1;
    t_prev = '0;
    exp_q.delete();
    exp_q.push_back('0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_dout"},   rx.data_out, 0);
    check_eq({tag, "_valid"},  rx.data_valid, 0);
    check_eq({tag, "_fs"},     rx.frame_start, 0);
    check_eq({tag, "_locked"}, rx.locked, 0);
    check_eq({tag, "_off"},    rx.bit_offset, 0);
    check_eq({tag, "_ll"},     rx.lock_loss_cnt, 0);
    check_eq({tag, "_he"},     rx.hdr_err_cnt, 0);
    check_eq({tag, "_state"},  rx.fsm_state, ST_HUNT);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    s_shift  = 0;
    t_prev   = '0;
    rx.data_in       = '0;
    rx.force_realign = 1'b0;

    hold_reset();
    check_all_zero("reset");

    // T1: unshifted stream, headers at index 3 mod 4; offset reaches 0 again at k=20.
    s_shift = 0;
    rxresetdone_in = 1'b1;
    for (int k = 0; k < 40; k++) begin
      drive(tword(k, 3, 0, 21), 1'b0);
      if (k < 20) check_eq("t1_hunt_off", rx.bit_offset, (k + 1) % 20);
      if (k == 20) begin
        check_eq("t1_verify_state", rx.fsm_state, ST_VERIFY);
        check_eq("t1_verify_off", rx.bit_offset, 0);
      end
      if (k == 31) check_eq("t1_not_yet_locked", rx.locked, 0);
      if (k >= 32) begin
        check_eq("t1_locked", rx.locked, 1);
        check_eq("t1_valid", rx.data_valid, 1);
        check_eq("t1_fs", rx.frame_start, ((k - 1) % 4 == 3) ? 1 : 0);
        check_eq("t1_dout", rx.data_out, exp_dout);
      end
    end

    // T2 + T3: stream delayed 7 bits, headers at index 2 mod 4, then header corruption.
    hold_reset();
    s_shift = 7;
    rxresetdone_in = 1'b1;
    for (int k = 0; k <= 43; k++) begin
      tw = tword(k, 2, 0, 8);
      if (k == 22 || k == 26 || k == 34 || k == 38 || k == 42) tw = tw ^ 20'h00010;
      drive(tw, 1'b0);
      if (k < 7) check_eq("t2_hunt_off", rx.bit_offset, k + 1);
      if (k == 7) begin
        check_eq("t2_hit_off", rx.bit_offset, 7);
        check_eq("t2_hit_state", rx.fsm_state, ST_VERIFY);
      end
      if (k == 18) check_eq("t2_not_yet_locked", rx.locked, 0);
      if (k >= 19 && k <= 22) begin
        check_eq("t2_locked", rx.locked, 1);
        check_eq("t2_off", rx.bit_offset, 7);
        check_eq("t2_fs", rx.frame_start, ((k - 1) % 4 == 2) ? 1 : 0);
        check_eq("t2_dout", rx.data_out, exp_dout);
      end
      if (k == 23) begin
        check_eq("t3_he1", rx.hdr_err_cnt, 1);
        check_eq("t3_lock1", rx.locked, 1);
      end
      if (k == 27) check_eq("t3_he2", rx.hdr_err_cnt, 2);
      if (k == 31) begin
        check_eq("t3_he_after_good", rx.hdr_err_cnt, 2);
        check_eq("t3_lock_after_good", rx.locked, 1);
        check_eq("t3_ll_zero", rx.lock_loss_cnt, 0);
      end
      if (k == 39) begin
        check_eq("t3_he4", rx.hdr_err_cnt, 4);
        check_eq("t3_lock_two_bad", rx.locked, 1);
      end
      if (k == 43) begin
        check_eq("t3_he5", rx.hdr_err_cnt, 5);
        check_eq("t3_unlocked", rx.locked, 0);
        check_eq("t3_valid_low", rx.data_valid, 0);
        check_eq("t3_ll1", rx.lock_loss_cnt, 1);
        check_eq("t3_off_kept", rx.bit_offset, 7);
        check_eq("t3_state", rx.fsm_state, ST_HUNT);
      end
    end

    // T4 + T5: lone SYNC payload word at index 6, real frames from index 30.
    hold_reset();
    s_shift = 7;
    rxresetdone_in = 1'b1;
    for (int k = 0; k <= 49; k++) begin
      tw = tword(k, 2, 30, 31);
      if (k == 6) tw = SYNC;
      if (k == 46) tw = tw ^ 20'h00100;
      drive(tw, (k == 47 || k == 48) ? 1'b1 : 1'b0);
      if (k == 7) begin
        check_eq("t4_false_hit_state", rx.fsm_state, ST_VERIFY);
        check_eq("t4_false_hit_off", rx.bit_offset, 7);
      end
      if (k == 11) begin
        check_eq("t4_miss_state", rx.fsm_state, ST_HUNT);
        check_eq("t4_miss_off", rx.bit_offset, 8);
      end
      if (k == 30) check_eq("t4_rehunt_off", rx.bit_offset, 7);
      if (k == 31) check_eq("t4_real_hit_state", rx.fsm_state, ST_VERIFY);
      if (k == 42) check_eq("t4_not_yet_locked", rx.locked, 0);
      if (k == 43) begin
        check_eq("t4_locked", rx.locked, 1);
        check_eq("t4_fs", rx.frame_start, 1);
        check_eq("t4_off", rx.bit_offset, 7);
      end
      if (k >= 43 && k <= 46) check_eq("t4_dout", rx.data_out, exp_dout);
      if (k == 47) begin
        check_eq("t5_state", rx.fsm_state, ST_HUNT);
        check_eq("t5_locked", rx.locked, 0);
        check_eq("t5_ll", rx.lock_loss_cnt, 1);
        check_eq("t5_he", rx.hdr_err_cnt, 1);
        check_eq("t5_off", rx.bit_offset, 7);
      end
      if (k == 48) begin
        check_eq("t5_ll_hunt_force", rx.lock_loss_cnt, 1);
        check_eq("t5_off_hold", rx.bit_offset, 7);
      end
      if (k == 49) check_eq("t5_slip_resumes", rx.bit_offset, 8);
    end

    // T6: lock at k=19, 16 forced losses, then 16 header errors; counters are 4 bits wide.
    hold_reset();
    s_shift = 7;
    nbad    = 0;
    rxresetdone_in = 1'b1;
    for (int k = 0; k <= 373; k++) begin
      logic fr;
      tw = tword(k, 2, 0, 8);
      fr = (k > 19 && k < 275 && (k - 19) % 16 == 3) ? 1'b1 : 1'b0;
      if (k >= 278 && k % 4 == 2 && ((k - 278) / 4) < 24 && ((k - 278) / 4) % 3 != 2) begin
        tw = tw ^ 20'h00001;
        nbad++;
      end
      drive(tw, fr);
      if (k == 19) check_eq("t6_first_lock", rx.locked, 1);
      if (fr) begin
        check_eq("t6_ll", rx.lock_loss_cnt, sat((k - 19) / 16 + 1));
        check_eq("t6_unlocked", rx.locked, 0);
      end
      if (k > 19 && k <= 275 && (k - 19) % 16 == 0) check_eq("t6_relock", rx.locked, 1);
      if (k >= 279 && (k - 1) % 4 == 2) begin
        check_eq("t6_he", rx.hdr_err_cnt, sat(nbad));
        check_eq("t6_he_locked", rx.locked, 1);
      end
    end
    check_eq("t6_ll_saturated", rx.lock_loss_cnt, 15);
    check_eq("t6_he_saturated", rx.hdr_err_cnt, 15);

    // Async reset mid-frame, away from any clock edge.
    #2;
    rxresetdone_in = 1'b0;
    #1;
    check_all_zero("t6_async");
    hold_reset();
    rxresetdone_in = 1'b1;
    for (int k = 0; k <= 19; k++) begin
      drive(tword(k, 2, 0, 8), 1'b0);
      if (k == 0) check_eq("t6_restart_off", rx.bit_offset, 1);
      if (k == 18) check_eq("t6_relock_pending", rx.locked, 0);
      if (k == 19) begin
        check_eq("t6_relock_after_reset", rx.locked, 1);
        check_eq("t6_relock_off", rx.bit_offset, 7);
        check_eq("t6_ll_cleared", rx.lock_loss_cnt, 0);
        check_eq("t6_he_cleared", rx.hdr_err_cnt, 0);
      end
    end

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
